// File: rtl/temperature_pkg.sv
// Shared defaults and state encoding for the temperature calculator.
package temperature_pkg;

  localparam int BASE_W_DEF = 32;
  localparam int REF_W_DEF  = 8;
  localparam int ADC_W_DEF  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

endpackage

// File: rtl/temperature_calculator_shift_add_mul_step.sv
// One shift-add multiply iteration: acc + (mul_bit ? operand << shift : 0), truncated.
module shift_add_mul_step #(
  parameter int BASE_W  = 32,
  parameter int ADC_W   = 16,
  parameter int SHIFT_W = 3
) (
  input  logic [BASE_W-1:0]  acc,
  input  logic [ADC_W-1:0]   operand,
  input  logic               mul_bit,
  input  logic [SHIFT_W-1:0] shift,
  output logic [BASE_W-1:0]  acc_next
);

  logic [BASE_W-1:0] operand_ext;
  logic [BASE_W-1:0] addend;

  always_comb begin
    operand_ext = BASE_W'(operand);
    addend      = mul_bit ? (operand_ext << shift) : '0;
    acc_next    = acc + addend;
  end

endmodule

// File: rtl/temperature_calculator.sv
// tempc = tc_base + tc_ref * adc_data (mod 2^BASE_W), one coefficient bit per clock.
module temperature_calculator
  import temperature_pkg::*;
#(
  parameter int BASE_W = BASE_W_DEF,
  parameter int REF_W  = REF_W_DEF,
  parameter int ADC_W  = ADC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BASE_W-1:0] tc_base,
  input  logic [REF_W-1:0]  tc_ref,
  input  logic [ADC_W-1:0]  adc_data,
  output logic              busy,
  output logic              done,
  output logic [BASE_W-1:0] tempc
);

  localparam int CNT_W = (REF_W > 1) ? $clog2(REF_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REF_W - 1);

  state_t            state_q;
  state_t            state_d;
  logic              load;
  logic              finish;
  logic [BASE_W-1:0] acc_q;
  logic [BASE_W-1:0] acc_next;
  logic [REF_W-1:0]  ref_q;
  logic [ADC_W-1:0]  adc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              done_q;
  logic [BASE_W-1:0] tempc_q;

  shift_add_mul_step #(
    .BASE_W  (BASE_W),
    .ADC_W   (ADC_W),
    .SHIFT_W (CNT_W)
  ) u_step (
    .acc      (acc_q),
    .operand  (adc_q),
    .mul_bit  (ref_q[cnt_q]),
    .shift    (cnt_q),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q == LAST_CNT) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands are latched at start so later input changes cannot disturb a running calculation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      ref_q   <= '0;
      adc_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      tempc_q <= '0;
    end else begin
      done_q <= finish;
      if (load) begin
        acc_q <= tc_base;
        ref_q <= tc_ref;
        adc_q <= adc_data;
        cnt_q <= '0;
      end else if (state_q == CALC) begin
        acc_q <= acc_next;
        cnt_q <= cnt_q + 1'b1;
        if (finish) begin
          tempc_q <= acc_next;
        end
      end
    end
  end

  assign busy  = (state_q == CALC);
  assign done  = done_q;
  assign tempc = tempc_q;

endmodule

// File: tb/tb_temperature_calculator.sv
// Directed self-checking bench for temperature_calculator.
module tb_temperature_calculator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] tc_base;
  logic [7:0]  tc_ref;
  logic [15:0] adc_data;
  logic        busy;
  logic        done;
  logic [31:0] tempc;

  int checks   = 0;
  int failures = 0;
  int lat;
  int busy_cnt;
  int done_seen;
  int busy_seen;

  temperature_calculator dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .tc_base  (tc_base),
    .tc_ref   (tc_ref),
    .adc_data (adc_data),
    .busy     (busy),
    .done     (done),
    .tempc    (tempc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drives operands and pulses start for exactly one sampling edge.
  task automatic applyStimulus(input logic [31:0] base, input logic [7:0] coef,
                               input logic [15:0] adc);
    tc_base  = base;
    tc_ref   = coef;
    adc_data = adc;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Counts edges from the start edge until done, bounded so a stuck DUT still reaches the summary.
  task automatic waitDone(output int latency, output int busy_cycles);
    latency     = 0;
    busy_cycles = busy ? 1 : 0;
    while (latency <= 20) begin
      tick();
      latency++;
      if (done) break;
      if (busy) busy_cycles++;
    end
  endtask

  initial begin
    rst_n    = 1'b1;
    start    = 1'b0;
    tc_base  = '0;
    tc_ref   = '0;
    adc_data = '0;
    #2 rst_n = 1'b0;
    tick();
    tick();
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_tempc", tempc, 32'h0);
    rst_n = 1'b1;
    tick();

    // Nominal
    applyStimulus(32'hAAAA_AAAA, 8'hC6, 16'hAAAA);
    waitDone(lat, busy_cnt);
    checkOutput("nominal_latency", lat, 32'd8);
    checkOutput("nominal_busy_cycles", busy_cnt, 32'd8);
    checkOutput("nominal_tempc", tempc, 32'hAB2E_AA26);
    checkOutput("nominal_busy_at_done", {31'd0, busy}, 32'd0);
    tick();
    checkOutput("nominal_done_one_cycle", {31'd0, done}, 32'd0);
    checkOutput("nominal_tempc_hold", tempc, 32'hAB2E_AA26);

    // Zero coefficient still takes full latency
    applyStimulus(32'h1234_5678, 8'h00, 16'hFFFF);
    waitDone(lat, busy_cnt);
    checkOutput("zero_latency", lat, 32'd8);
    checkOutput("zero_tempc", tempc, 32'h1234_5678);
    tick();

    // All-ones wrap
    applyStimulus(32'hFFFF_FFFF, 8'hFF, 16'hFFFF);
    waitDone(lat, busy_cnt);
    checkOutput("wrap_latency", lat, 32'd8);
    checkOutput("wrap_tempc", tempc, 32'h00FE_FF00);
    tick();

    // Start held during busy with changed operands, then back-to-back on the done cycle
    tc_base  = 32'h0000_0100;
    tc_ref   = 8'h03;
    adc_data = 16'h0005;
    start    = 1'b1;
    tick();
    tc_base  = 32'h0;
    tc_ref   = 8'hFF;
    adc_data = 16'hFFFF;
    waitDone(lat, busy_cnt);
    checkOutput("held_latency", lat, 32'd8);
    checkOutput("held_tempc", tempc, 32'h0000_010F);
    tc_base  = 32'h0;
    tc_ref   = 8'h02;
    adc_data = 16'h0003;
    tick();
    start = 1'b0;
    checkOutput("b2b_busy_after_accept", {31'd0, busy}, 32'd1);
    waitDone(lat, busy_cnt);
    checkOutput("b2b_latency", lat, 32'd8);
    checkOutput("b2b_tempc", tempc, 32'h0000_0006);
    tick();

    // Input isolation mid-calculation
    applyStimulus(32'h0000_1000, 8'h05, 16'h0003);
    tick();
    tick();
    tc_base  = 32'h0;
    tc_ref   = 8'hFF;
    adc_data = 16'hFFFF;
    waitDone(lat, busy_cnt);
    checkOutput("iso_latency", lat + 2, 32'd8);
    checkOutput("iso_tempc", tempc, 32'h0000_100F);
    tick();

    // Asynchronous reset in cycle 4 of CALC
    applyStimulus(32'hAAAA_AAAA, 8'hC6, 16'hAAAA);
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_mid_done", {31'd0, done}, 32'd0);
    checkOutput("rst_mid_tempc", tempc, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    done_seen = 0;
    busy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    checkOutput("post_rst_no_done", done_seen, 32'd0);
    checkOutput("post_rst_no_busy", busy_seen, 32'd0);

    applyStimulus(32'h0, 8'h02, 16'h0003);
    waitDone(lat, busy_cnt);
    checkOutput("post_rst_latency", lat, 32'd8);
    checkOutput("post_rst_tempc", tempc, 32'h0000_0006);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
